// File: rtl/multiplier8_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the FSM encoding and the default operand width.
package multiplier8_seq_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fulladder8.sv
// N-bit ripple adder with carry in/out; the multiplier uses it to add
// the multiplicand into the upper half of the accumulator.
module fulladder8 #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/multiplier8_seq.sv
// Unsigned N x N sequential multiplier: one shift-add step per cycle,
// N steps, then a one-cycle done pulse with the product held on P.
module multiplier8_seq
    import multiplier8_seq_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] P,
    output logic           busy,
    output logic           done
);

    localparam int CNT_W = $clog2(N + 1);

    state_t           state_q, state_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   p_q, p_d;

    logic [N-1:0]     addend;
    logic [N-1:0]     psum;
    logic             pcarry;

    assign addend = mplier_q[0] ? mcand_q : '0;

    fulladder8 #(.N(N)) u_add (
        .a    (acc_q[2*N-1:N]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (psum),
        .cout (pcarry)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CALC;
                    mcand_d  = A;
                    mplier_d = B;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            ST_CALC: begin
                // carry becomes the new MSB as {carry, acc} shifts right
                acc_d    = {pcarry, psum, acc_q[N-1:1]};
                mplier_d = mplier_q >> 1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = ST_DONE;
                    p_d     = acc_d;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    assign P    = p_q;
    assign busy = (state_q == ST_CALC) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);

endmodule
